// File: rtl/apb_reg_decoder_n.sv
// apb_reg_decoder_n
//   APB slave front-end for a peripheral register bank. Decodes a base-address
//   window into NUM_REGS register slots, issues one-cycle write/read strobes to
//   the backend, waits on per-slot ready (with timeout), and returns read data
//   and PSLVERR on the APB side. All outputs are registered.
//
// Ports
//   i_PCLK       APB clock
//   i_PRESET     asynchronous active-high reset
//   i_PSEL       APB select
//   i_PENABLE    APB enable
//   i_PWRITE     1=write, 0=read
//   i_PADDR      APB address
//   i_PWDATA     APB write data
//   i_BASE_ADDR  window base, compared to i_PADDR[ADDR_W-1:BASE_LSB]
//   i_RDATA      packed per-slot read data, slot k at [k*DATA_W +: DATA_W]
//   i_REG_READY  per-slot backend ready
//   o_WR         one-hot write strobe
//   o_RD         one-hot read strobe
//   o_WDATA      registered write data to backend
//   o_PRDATA     APB read data
//   o_PREADY     APB ready
//   o_PSLVERR    APB error, valid with o_PREADY
module apb_reg_decoder_n #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int BASE_LSB = 6,
  parameter int TIMEOUT  = 15
) (
  input  logic                         i_PCLK,
  input  logic                         i_PRESET,
  input  logic                         i_PSEL,
  input  logic                         i_PENABLE,
  input  logic                         i_PWRITE,
  input  logic [ADDR_W-1:0]            i_PADDR,
  input  logic [DATA_W-1:0]            i_PWDATA,
  input  logic [ADDR_W-BASE_LSB-1:0]   i_BASE_ADDR,
  input  logic [NUM_REGS*DATA_W-1:0]   i_RDATA,
  input  logic [NUM_REGS-1:0]          i_REG_READY,
  output logic [NUM_REGS-1:0]          o_WR,
  output logic [NUM_REGS-1:0]          o_RD,
  output logic [DATA_W-1:0]            o_WDATA,
  output logic [DATA_W-1:0]            o_PRDATA,
  output logic                         o_PREADY,
  output logic                         o_PSLVERR
);

  localparam int IDX_W = BASE_LSB - 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                wr_flag;
  logic                err;
  logic [CNT_W-1:0]    cnt;

  logic [IDX_W-1:0]    setup_idx;
  logic                setup;
  logic                idx_ok;
  logic [NUM_REGS-1:0] setup_onehot;
  logic                ready_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic                resp_go;
  logic                resp_err;

  assign setup_idx = i_PADDR[BASE_LSB-1:2];
  assign setup = i_PSEL && !i_PENABLE &&
                 (i_PADDR[ADDR_W-1:BASE_LSB] == i_BASE_ADDR);

  // Slot decode by loop so an index beyond NUM_REGS simply matches nothing
  // instead of selecting out of range.
  always_comb begin
    idx_ok       = 1'b0;
    setup_onehot = '0;
    ready_sel    = 1'b0;
    rdata_sel    = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (setup_idx == IDX_W'(k)) begin
        idx_ok          = 1'b1;
        setup_onehot[k] = 1'b1;
      end
      if (idx == IDX_W'(k)) begin
        ready_sel = i_REG_READY[k];
        rdata_sel = i_RDATA[k*DATA_W +: DATA_W];
      end
    end
  end

  // Response decision for the STROBE/WAIT states; the PSEL-drop abort has
  // priority and is handled in the sequential block.
  always_comb begin
    resp_go  = 1'b0;
    resp_err = 1'b0;
    case (state)
      STROBE: begin
        if (err) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else if (ready_sel) begin
          resp_go  = 1'b1;
        end
      end
      WAIT: begin
        if (ready_sel) begin
          resp_go  = 1'b1;
        end else if (cnt == CNT_MAX) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state     <= IDLE;
      idx       <= '0;
      wr_flag   <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      o_WR      <= '0;
      o_RD      <= '0;
      o_WDATA   <= '0;
      o_PRDATA  <= '0;
      o_PREADY  <= 1'b0;
      o_PSLVERR <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle after the setup edge.
      o_WR <= '0;
      o_RD <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (setup) begin
            idx     <= setup_idx;
            wr_flag <= i_PWRITE;
            err     <= !idx_ok;
            o_WDATA <= i_PWDATA;
            if (i_PWRITE) o_WR <= setup_onehot;
            else          o_RD <= setup_onehot;
            state   <= STROBE;
          end
        end
        STROBE, WAIT: begin
          if (!i_PSEL) begin
            state <= IDLE;
          end else if (resp_go) begin
            o_PREADY  <= 1'b1;
            o_PSLVERR <= resp_err;
            o_PRDATA  <= (!resp_err && !wr_flag) ? rdata_sel : '0;
            state     <= RESP;
          end else if (state == STROBE) begin
            cnt   <= CNT_W'(1);
            state <= WAIT;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          o_PREADY  <= 1'b0;
          o_PSLVERR <= 1'b0;
          o_PRDATA  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_reg_decoder_n.md
Name: apb_reg_decoder_n

Overview:
- Parametrised APB slave front-end.
- Decodes a base-address window into NUM_REGS register slots and issues one-cycle write/read strobes to a peripheral register bank, such as the SPI core.
- Muxes per-slot read data back onto PRDATA.
- Adds features the previous-generation interface lacks: backend wait-states through per-slot ready, a timeout, and PSLVERR on bad index or timeout.

Parameters:
ADDR_W, 16, APB address width
DATA_W, 8, APB data width
NUM_REGS, 8, number of register slots (1..2^(BASE_LSB-2))
BASE_LSB, 6, lowest address bit of the base compare; slot index = PADDR[BASE_LSB-1:2]
TIMEOUT, 15, maximum cycles to wait for backend ready after strobe (>=1)

Ports:
i_PCLK  in  1  APB clock
i_PRESET  in  1  asynchronous active-high reset
i_PSEL  in  1  APB select
i_PENABLE  in  1  APB enable
i_PWRITE  in  1  1=write, 0=read
i_PADDR  in  ADDR_W  APB address
i_PWDATA  in  DATA_W  APB write data
i_BASE_ADDR  in  ADDR_W-BASE_LSB  window base, compared to PADDR[ADDR_W-1:BASE_LSB]
i_RDATA  in  NUM_REGS*DATA_W  packed read data; slot k at [k*DATA_W +: DATA_W]
i_REG_READY  in  NUM_REGS  per-slot backend ready
o_WR  out  NUM_REGS  one-hot write strobe
o_RD  out  NUM_REGS  one-hot read strobe
o_WDATA  out  DATA_W  registered write data to backend
o_PRDATA  out  DATA_W  APB read data
o_PREADY  out  1  APB ready
o_PSLVERR  out  1  APB error, valid with o_PREADY

Behaviour:
- All outputs are registered.
- Reset is asynchronous. While i_PRESET=1, all outputs are 0, the FSM is IDLE and the counter is 0. Reset mid-transfer aborts the transfer immediately, with no completion.
- FSM states: IDLE, STROBE, WAIT, RESP.

IDLE:
- Setup is detected when i_PSEL=1, i_PENABLE=0, and the base matches.
- On setup: latch idx, write flag and i_PWDATA; o_WDATA <= i_PWDATA.
- If idx < NUM_REGS: o_WR[idx] <= i_PWRITE and o_RD[idx] <= !i_PWRITE. Go to STROBE.
- If idx >= NUM_REGS: no strobe; set the error flag and go to STROBE.
- Base mismatch or PSEL=0: stay in IDLE, drive nothing. o_PREADY stays 0, and the fabric default slave owns that transfer.

STROBE (first ACCESS cycle):
- The strobe is high for exactly this one cycle and is cleared at the next edge.
- If the error flag is set: go to RESP with PSLVERR=1.
- Else if i_REG_READY[idx]=1: go to RESP.
- Else: counter <= 1, go to WAIT.

WAIT:
- If i_REG_READY[idx]=1: go to RESP.
- Else if counter == TIMEOUT: go to RESP with PSLVERR=1.
- Else: counter++.

RESP entry (registered):
- o_PREADY <= 1.
- o_PSLVERR <= error.
- o_PRDATA <= slot data, only for an error-free read; otherwise 0.
- RESP lasts one cycle. Next edge: o_PREADY, o_PSLVERR and o_PRDATA clear to 0; go to IDLE. Back-to-back setup is accepted from IDLE on the following cycle.

Latency:
- With ready high at strobe, o_PREADY is high in the 2nd ACCESS cycle (1 wait state).
- Each extra ready-low cycle adds one wait state.
- A timeout completes in the (TIMEOUT+2)th ACCESS cycle.

Other rules:
- i_PSEL dropped in STROBE or WAIT: abort to IDLE with no PREADY. A strobe already issued is not retracted.
- o_WDATA holds its value until the next accepted setup; it is not zeroed between transfers.
- i_RDATA is sampled only at the RESP-entry edge. The counter saturates and never wraps.
- Strobe one-hot rule: at most one bit of o_WR|o_RD is high in any cycle.

Test Plan:
1. Write, ready tied high. Defaults; base 10'h001; PADDR=16'h0048 (idx 2), PWDATA=8'hA5.
   -> o_WR=8'b00000100 for exactly 1 cycle, o_WDATA=8'hA5.
   -> o_PREADY=1 in the 2nd ACCESS cycle with PSLVERR=0; o_PRDATA=0.
2. Read idx 5 (PADDR=16'h0054), i_RDATA slot5=8'h3C, ready for slot 5 held low 3 cycles after the strobe.
   -> o_RD=8'b00100000 for one cycle.
   -> PREADY after 4 wait states, o_PRDATA=8'h3C, PSLVERR=0.
3. Timeout: read idx 1 with ready never asserted, TIMEOUT=15.
   -> o_PREADY=1 with o_PSLVERR=1 and o_PRDATA=0 in the 17th ACCESS cycle; then back to IDLE.
4. Bad index: NUM_REGS=4, PADDR=16'h0058 (idx 6).
   -> no bit of o_WR/o_RD set; PREADY=1 and PSLVERR=1 in the 2nd ACCESS cycle.
5. Base mismatch: PADDR=16'h0088.
   -> no strobe, o_PREADY stays 0 through a 5-cycle ACCESS; FSM stays IDLE.
6. Reset in WAIT: assert i_PRESET asynchronously between edges during test 3.
   -> all outputs 0 immediately; next setup after release behaves as in test 1.
